// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg: shared state encoding and default widths for the RAM access controller.
package ram_access_ctrl_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready request/response sequencer for a 32x32 synchronous RAM.
// Define RAM_ACCESS_CTRL_BURST_EN to honour req_len (1-4 beat bursts with address wrap).
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              mem_cs,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state, state_n;
    logic we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic last;
    logic accept;
`ifdef RAM_ACCESS_CTRL_BURST_EN
    logic [LEN_W-1:0] cnt_q;
    assign last = cnt_q == '0;
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign last = 1'b1;
`endif
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = state == RESP;
    assign rsp_last  = rsp_valid && last;
    assign rsp_rdata = rdata_q;
    assign mem_cs    = state == ISSUE;
    assign mem_rw    = (state == ISSUE) ? ~we_q : 1'b1;
    assign mem_addr  = addr_q;
    // wdata_q only loads on write requests, so it holds the previous value across reads
    assign mem_wdata = wdata_q;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = we_q ? RESP : WAIT;
            WAIT:    state_n = RESP;
            RESP:    state_n = rsp_ready ? (last ? IDLE : ISSUE) : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ACCESS_CTRL_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                if (req_we) wdata_q <= req_wdata;
`ifdef RAM_ACCESS_CTRL_BURST_EN
                cnt_q  <= req_len;
`endif
            end
            if (state == ISSUE && we_q) rdata_q <= '0;
            if (state == WAIT) rdata_q <= mem_rdata;
`ifdef RAM_ACCESS_CTRL_BURST_EN
            if (state == RESP && rsp_ready && !last) begin
                cnt_q  <= cnt_q - 1'b1;
                addr_q <= addr_q + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed table, corner-case sequences and random traffic against a shadow-memory model.
module tb_ram_access_ctrl;
`ifdef RAM_ACCESS_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_we = 1'b0;
    logic [4:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0] req_len = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic rsp_last;
    logic mem_cs;
    logic mem_rw;
    logic [4:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] ram [32];
    logic [31:0] shadow [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // behavioural 32x32 synchronous RAM downstream of the controller
    always @(posedge clk) begin
        if (mem_cs) begin
            if (!mem_rw) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int beats(input logic [1:0] len);
        return BURST ? int'(len) + 1 : 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // one request; every beat is compared against the shadow memory model
    task automatic run_req(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input logic [1:0] len, input bit rnd, output logic [31:0] first);
        int nb;
        int cyc;
        int lat;
        bit busy_ok;
        bit stall_ok;
        nb = beats(len);
        cyc = 0;
        lat = -1;
        busy_ok = 1'b1;
        stall_ok = 1'b1;
        first = 'x;
        wait_ready();
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_len = len;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < nb; i++) begin
            logic [4:0] ba;
            logic [31:0] exp;
            logic [31:0] prev;
            bit prev_v;
            int n;
            ba = a + 5'(i);
            exp = we ? 32'd0 : shadow[ba];
            if (we) shadow[ba] = d;
            prev_v = 1'b0;
            prev = '0;
            n = 0;
            while (n < 40) begin
                if (req_ready) busy_ok = 1'b0;
                if (rsp_valid) begin
                    if (prev_v && rsp_rdata !== prev) stall_ok = 1'b0;
                    if (lat < 0) lat = cyc;
                    rsp_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
                    if (rsp_ready) break;
                    prev = rsp_rdata;
                    prev_v = 1'b1;
                end
                @(negedge clk);
                cyc++;
                n++;
            end
            if (n >= 40) begin
                check($sformatf("beat_timeout a=%0d beat=%0d", a, i), 32'd0, 32'd1);
                return;
            end
            if (i == 0) first = rsp_rdata;
            check($sformatf("rdata a=%0d beat=%0d", a, i), rsp_rdata, exp);
            check($sformatf("last a=%0d beat=%0d", a, i), 32'(rsp_last), 32'(i == nb - 1));
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b1;
        check($sformatf("latency we=%0d", we), lat, we ? 32'd2 : 32'd3);
        check("busy_req_ready_low", 32'(busy_ok), 32'd1);
        check("stall_stable", 32'(stall_ok), 32'd1);
        check("idle_after_last", {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic we;
        logic [4:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic [31:0] got;
        logic [31:0] held;
        bit quiet;
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        32'h12345678};
        tbl[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 32'h0};
        tbl[5] = '{1'b0, 5'd31, 32'h0,        32'hCAFEF00D};
        tbl[6] = '{1'b1, 5'd5,  32'h00000000, 32'h0};
        tbl[7] = '{1'b0, 5'd5,  32'h0,        32'h00000000};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_cs", 32'(mem_cs), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 32; i++) run_req(1'b1, 5'(i), 32'hB000_0000 | i, 2'd0, 1'b0, got);

        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].we, tbl[i].a, tbl[i].d, 2'd0, 1'b0, got);
            check($sformatf("table[%0d]", i), got, tbl[i].exp);
        end

        // backpressure with a pending request held by the requester
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0; req_len = 2'd0; rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 5'd7; req_wdata = 32'h0000_0077;
        @(negedge clk);
        @(negedge clk);
        check("bp_first_valid", 32'(rsp_valid), 32'd1);
        held = rsp_rdata;
        check("bp_first_data", held, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid[%0d]", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_rdata[%0d]", i), rsp_rdata, held);
            check($sformatf("bp_req_ready[%0d]", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_wack_valid", 32'(rsp_valid), 32'd1);
        check("bp_wack_data", rsp_rdata, 32'd0);
        check("bp_wack_last", 32'(rsp_last), 32'd1);
        shadow[7] = 32'h0000_0077;
        @(negedge clk);
        run_req(1'b0, 5'd7, 32'd0, 2'd0, 1'b0, got);
        check("bp_pending_write", got, 32'h0000_0077);

        // burst across the 31->0 wrap
        for (int i = 0; i < 4; i++) run_req(1'b1, 5'd30 + 5'(i), 32'hA0 + i, 2'd0, 1'b0, got);
        run_req(1'b0, 5'd30, 32'd0, 2'd3, 1'b0, got);
        check("burst_first", got, 32'hA0);

        // reset in WAIT (of beat 2 when bursts are enabled)
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd10; req_len = 2'd3; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (BURST ? 4 : 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_mem_cs", 32'(mem_cs), 32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_idle", 32'(req_ready), 32'd1);
        quiet = 1'b1;
        repeat (6) begin
            if (rsp_valid || mem_cs) quiet = 1'b0;
            @(negedge clk);
        end
        check("rstw_no_more_beats", 32'(quiet), 32'd1);

        // reset coinciding with a write's ISSUE edge
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 32'h9999_0009; req_len = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rsti_issue_cs", 32'(mem_cs), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        shadow[9] = 32'h9999_0009;
        quiet = 1'b1;
        repeat (4) begin
            if (rsp_valid) quiet = 1'b0;
            @(negedge clk);
        end
        check("rsti_no_ack", 32'(quiet), 32'd1);
        run_req(1'b0, 5'd9, 32'd0, 2'd0, 1'b0, got);
        check("rsti_committed", got, 32'h9999_0009);

        // random traffic with random backpressure
        repeat (40) begin
            run_req(1'($urandom), 5'($urandom), $urandom, 2'($urandom), 1'b1, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request/response controller directly upstream of the 32x32 synchronous RAM (ram32x32 array). It accepts read/write requests over a valid/ready handshake and sequences the RAM's `cs`/`rw`/`addr`/data pins. It returns read data, or a write acknowledge, over a second valid/ready handshake. The RAM's tri-state data pin is resolved at the top level: this block sees separate write and read data buses.

## Interface
**Parameters**
- `ADDR_W`, default 5: RAM address width.
- `DATA_W`, default 32: RAM word width.

**Ports**
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: start address.
- `req_wdata`  in  DATA_W: write data.
- `req_len`  in  2: beats minus 1; used only with the burst feature.
- `rsp_valid`  out  1: response beat present.
- `rsp_ready`  in  1: consumer accepts the beat.
- `rsp_rdata`  out  DATA_W: read data; 0 for a write acknowledge.
- `rsp_last`  out  1: final beat of the request.
- `mem_cs`  out  1: RAM chip select.
- `mem_rw`  out  1: RAM direction; 1 = read, 0 = write.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  DATA_W: RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data; valid the cycle after a read is sampled.

## Operation
**States:** IDLE, ISSUE, WAIT, RESP.

**IDLE**
- `req_ready`=1.
- On `req_valid`&&`req_ready`, latch `we`/`addr`/`wdata`/`len` and set the beat counter = `len`. Go to ISSUE.

**ISSUE** (exactly one cycle)
- `mem_cs`=1, `mem_rw`=~`we`, `mem_addr`=current address.
- `mem_wdata`=latched data for a write; otherwise hold the previous value.
- Next state: WAIT for a read, RESP for a write.

**WAIT** (read only)
- `mem_cs`=0.
- Capture `mem_rdata` into `rsp_rdata` at the closing edge, then go to RESP.

**RESP**
- `rsp_valid`=1. `rsp_rdata` is stable until the handshake.
- `rsp_last`=1 when the beat counter = 0.
- On `rsp_ready`:
  - counter = 0: go to IDLE.
  - counter > 0: decrement the counter, address+1 mod 2^ADDR_W (31 wraps to 0), go to ISSUE.
- **Write bursts:** all beats write the same latched `wdata`.
- **Write acknowledge:** each write beat produces one response beat with `rsp_rdata`=0.

**Rules**
- `req_ready`=0 in every state except IDLE. A request arriving while busy is held by the requester and is not lost.
- `mem_cs`=0 in every state except ISSUE.
- **Reset values:** state=IDLE, `req_ready`=0 during the reset cycle and 1 afterwards. `rsp_valid`=0, `rsp_last`=0, `rsp_rdata`=0, `mem_cs`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-operation:** abort immediately; remaining beats are discarded and no response is produced.
  - A write whose ISSUE cycle coincides with the reset edge is committed by the RAM.
- **No pipelining:** a new request is accepted only in IDLE, so at most one is outstanding.

## Timing
Accept edge = edge 0.
- **Read:**
  - ISSUE in cycle 1; the RAM samples at edge 1.
  - WAIT in cycle 2; capture at edge 2.
  - `rsp_valid` in cycle 3.
  - Minimum latency 3 cycles.
- **Write:**
  - ISSUE in cycle 1; the RAM commits at edge 1.
  - `rsp_valid` in cycle 2.
- **Beat period:** with `rsp_ready` held at 1, the next beat's ISSUE follows the RESP handshake edge.
  - Read beat period: 3 cycles.
  - Write beat period: 2 cycles.
- **Back-to-back requests:** IDLE is entered after the final handshake. The next request is accepted no earlier than 1 cycle after that handshake.
- **Stall:** `rsp_ready`=0 holds RESP indefinitely with all outputs stable.

## Configuration
- **`RAM_ACCESS_CTRL_BURST_EN` defined:** `req_len` is honoured; bursts of 1–4 beats with address wrap.
- **Undefined:**
  - `req_len` is ignored and treated as 0.
  - Every request is a single beat with `rsp_last`=1.
  - No beat counter or address incrementer is synthesised.

## Structure
- **Package `ram_access_ctrl_pkg`:**
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - default `ADDR_W`/`DATA_W` constants;
  - `LEN_W`=2.
- **Single module:** the FSM and the datapath registers are small, so no sub-module.

## Test plan
1. **Write then read:** write 0xDEADBEEF to address 5, then read address 5.
   - Write ack `rsp_rdata`=0, `rsp_last`=1, 2 cycles after accept.
   - Read returns 0xDEADBEEF 3 cycles after accept.
2. **Backpressure:** read with `rsp_ready`=0 for 4 cycles.
   - `rsp_valid` and `rsp_rdata` held stable.
   - `req_ready`=0 throughout; a pending request is accepted only after returning to IDLE.
3. **Burst wrap (BURST_EN):** preload 30,31,0,1 with 0xA0..0xA3; read from address 30 with `len`=3.
   - Four beats 0xA0,0xA1,0xA2,0xA3; `rsp_last` on the 4th beat only.
4. **No BURST_EN:** same request as scenario 3.
   - Single beat 0xA0 with `rsp_last`=1.
5. **Reset mid-burst:** assert `rst` in WAIT of beat 2.
   - Next cycle: `rsp_valid`=0, `mem_cs`=0, state IDLE.
   - No further beats are produced.
   - `req_ready`=1 the cycle after reset deasserts.
6. **Reset during write ISSUE:** assert `rst` during a write's ISSUE cycle.
   - A subsequent read of that address returns the new data.
   - No write ack is produced.
